// File: rtl/wb_trap_unit.sv
// Write-back trap controller: prioritised exceptions, mret and arm/flush-gated interrupts.
// Optional TRAP_IRQ_SYNC_EN adds 2-flop synchronisers on all interrupt lines before mip.
module wb_trap_unit #(
  parameter int XLEN          = 32,
  parameter int NUM_LOCAL_IRQ = 16,
  parameter int FLUSH_CYCLES  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_stall,
  input  logic                     wb_valid,
  input  logic [XLEN-1:0]          wb_pc,
  input  logic [XLEN-1:0]          wb_fault_address,
  input  logic [31:0]              wb_instruction,
  input  logic [3:0]               exc_flags,
  input  logic                     mret,
  input  logic                     next_instruction_valid,
  input  logic [XLEN-1:0]          next_instruction_pc,
  input  logic                     software_interrupt,
  input  logic                     timer_interrupt,
  input  logic                     external_interrupt,
  input  logic [NUM_LOCAL_IRQ-1:0] local_interrupt,
  input  logic [XLEN-3:0]          mtvec_base,
  input  logic [1:0]               mtvec_mode,
  input  logic                     mstatus_mie,
  input  logic                     mstatus_mpie,
  input  logic [XLEN-1:0]          mie,
  input  logic [XLEN-1:0]          mepc_value,
  output logic                     trap_take,
  output logic [XLEN-1:0]          trap_pc,
  output logic                     mcause_interrupt,
  output logic [XLEN-2:0]          mcause_code,
  output logic [XLEN-1:0]          mepc_wdata,
  output logic [XLEN-1:0]          mtval_wdata,
  output logic                     mstatus_mie_wdata,
  output logic                     mstatus_mpie_wdata,
  output logic [1:0]               mstatus_mpp_wdata,
  output logic [XLEN-1:0]          mip_value
);

  localparam int NIRQ = NUM_LOCAL_IRQ + 3;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  // state | meaning
  // IDLE  | no eligible interrupt seen
  // ARMED | interrupt eligible, waiting for a valid restart point in MEM
  // FLUSH | pipe refilling after a redirect; interrupts masked
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] mip_q, mip_d, pend, tvec_base, vec_pc;
  logic [NIRQ-1:0] irq_raw, irq_line;
  logic            irq_elig, exc_any, exc_take, mret_take, irq_take;
  logic [XLEN-2:0] irq_code, exc_code;
  logic [XLEN-1:0] exc_mtval;

  assign irq_raw = {local_interrupt, external_interrupt, timer_interrupt, software_interrupt};

`ifdef TRAP_IRQ_SYNC_EN
  logic [NIRQ-1:0] sync_q1, sync_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_raw;
      sync_q2 <= sync_q1;
    end
  end
  assign irq_line = sync_q2;
`else
  assign irq_line = irq_raw;
`endif

  always_comb begin
    mip_d     = '0;
    mip_d[3]  = irq_line[0];
    mip_d[7]  = irq_line[1];
    mip_d[11] = irq_line[2];
    for (int i = 0; i < NUM_LOCAL_IRQ; i++) mip_d[16+i] = irq_line[3+i];
  end

  assign mip_value = mip_q;
  assign pend      = mip_q & mie;
  assign irq_elig  = mstatus_mie & (|pend);

  // Lowest local index wins among locals; standard lines override in rising priority.
  always_comb begin
    irq_code = '0;
    for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
      if (pend[16+i]) irq_code = (XLEN-1)'(16 + i);
    end
    if (pend[7])  irq_code = (XLEN-1)'(7);
    if (pend[3])  irq_code = (XLEN-1)'(3);
    if (pend[11]) irq_code = (XLEN-1)'(11);
  end

  assign exc_any = |exc_flags;

  always_comb begin
    exc_code  = (XLEN-1)'(6);
    exc_mtval = wb_fault_address;
    if (exc_flags[0]) begin
      exc_code  = '0;
      exc_mtval = wb_pc;
    end else if (exc_flags[1]) begin
      exc_code  = (XLEN-1)'(2);
      exc_mtval = XLEN'(wb_instruction);
    end else if (exc_flags[2]) begin
      exc_code  = (XLEN-1)'(4);
    end
  end

  assign tvec_base = {mtvec_base, 2'b00};
  assign vec_pc    = (mtvec_mode == 2'd1) ? tvec_base + {irq_code[XLEN-3:0], 2'b00} : tvec_base;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exc_take  = 1'b0;
    mret_take = 1'b0;
    irq_take  = 1'b0;
    if (!rst && !wb_stall) begin
      exc_take  = wb_valid & exc_any;
      mret_take = wb_valid & mret & ~exc_any;
      if (exc_take || mret_take) begin
        state_d = FLUSH;
        cnt_d   = FLUSH_LOAD;
      end else begin
        case (state_q)
          IDLE: if (irq_elig) state_d = ARMED;
          ARMED: begin
            if (next_instruction_valid && irq_elig) begin
              irq_take = 1'b1;
              state_d  = FLUSH;
              cnt_d    = FLUSH_LOAD;
            end else if (!irq_elig) begin
              state_d = IDLE;
            end
          end
          FLUSH: begin
            if (cnt_q == 4'd0) state_d = IDLE;
            else               cnt_d   = cnt_q - 4'd1;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    trap_take          = exc_take | mret_take | irq_take;
    trap_pc            = '0;
    mcause_interrupt   = 1'b0;
    mcause_code        = '0;
    mepc_wdata         = '0;
    mtval_wdata        = '0;
    mstatus_mie_wdata  = 1'b0;
    mstatus_mpie_wdata = 1'b0;
    mstatus_mpp_wdata  = 2'b00;
    if (exc_take) begin
      trap_pc            = tvec_base;
      mcause_code        = exc_code;
      mepc_wdata         = wb_pc;
      mtval_wdata        = exc_mtval;
      mstatus_mpie_wdata = mstatus_mie;
      mstatus_mpp_wdata  = 2'b11;
    end else if (irq_take) begin
      trap_pc            = vec_pc;
      mcause_interrupt   = 1'b1;
      mcause_code        = irq_code;
      mepc_wdata         = next_instruction_pc;
      mstatus_mpie_wdata = mstatus_mie;
      mstatus_mpp_wdata  = 2'b11;
    end else if (mret_take) begin
      trap_pc            = mepc_value;
      mstatus_mie_wdata  = mstatus_mpie;
      mstatus_mpie_wdata = 1'b1;
      mstatus_mpp_wdata  = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mip_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mip_q   <= mip_d;
    end
  end

endmodule
